// File: rtl/glbl_fifo_reader_if.sv
// ---------------------------------------------------------------------------
// glbl_fifo_reader_if
//   Groups the FIFO read side and the framed output beat stream of the
//   global event FIFO reader.
//
//   FIFO side : FIFO_DOUT (read data, valid one cycle after FIFO_RD_EN),
//               FIFO_EMPTY, FIFO_RD_EN (pop strobe)
//   Beat side : M_DATA, M_VALID, M_READY, M_SOP, M_EOP, M_CHAN, M_BC
//
//   modport master : the reader (drives FIFO_RD_EN and the M_* beat outputs)
//   modport slave  : the environment (FIFO plus downstream consumer)
// ---------------------------------------------------------------------------
interface glbl_fifo_reader_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] FIFO_DOUT;
   logic             FIFO_EMPTY;
   logic             FIFO_RD_EN;
   logic [WIDTH-1:0] M_DATA;
   logic             M_VALID;
   logic             M_READY;
   logic             M_SOP;
   logic             M_EOP;
   logic [2:0]       M_CHAN;
   logic [11:0]      M_BC;

   modport master (
      input  FIFO_DOUT, FIFO_EMPTY, M_READY,
      output FIFO_RD_EN, M_DATA, M_VALID, M_SOP, M_EOP, M_CHAN, M_BC
   );

   modport slave (
      output FIFO_DOUT, FIFO_EMPTY, M_READY,
      input  FIFO_RD_EN, M_DATA, M_VALID, M_SOP, M_EOP, M_CHAN, M_BC
   );
endinterface

// File: rtl/glbl_fifo_reader.sv
// ---------------------------------------------------------------------------
// glbl_fifo_reader
//   Drains the global event FIFO and frames its word stream into events:
//   one header {1'b0, CHSEL[2:0], BC[11:0]} followed by HOWMANY samples.
//   Each event leaves as a valid/ready beat stream tagged SOP/EOP with the
//   channel and BC of the event the beat belongs to.
//
//   Ports
//     CK50     : clock, all logic on the rising edge
//     RST      : asynchronous active-high reset (FIFO is reset alongside)
//     bus      : glbl_fifo_reader_if.master (FIFO read side + beat stream)
//     HOWMANY  : samples per event, captured when a header arrives
//     BUSY     : high while an event is partially delivered
//     FRM_ERR  : sticky framing error, cleared only by RST
//
//   Optional feature, macro GLBL_RDR_TIMEOUT_EN:
//     a stall in DATA with the FIFO empty for 16'hFFFF cycles closes the
//     event with a 16'hDEAD EOP beat, sets FRM_ERR and returns to HDR.
// ---------------------------------------------------------------------------
module glbl_fifo_reader #(
   parameter int SIZE  = 8,
   parameter int WIDTH = 16
) (
   input  logic                  CK50,
   input  logic                  RST,
   glbl_fifo_reader_if.master    bus,
   input  logic [SIZE-1:0]       HOWMANY,
   output logic                  BUSY,
   output logic                  FRM_ERR
);

   typedef enum logic [0:0] {
      ST_HDR  = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sop;
      logic             eop;
      logic [2:0]       chan;
      logic [11:0]      bc;
   } entry_t;

   state_t           state_r, next_state_s;
   logic [SIZE-1:0]  rem_r, next_rem_s;
   logic [2:0]       chan_r, next_chan_s;
   logic [11:0]      bc_r, next_bc_s;
   logic             inflight_r;
   logic [1:0]       occ_r;
   entry_t           head_r, tail_r;
   logic             busy_r;
   logic             frm_err_r;

   logic             arrive_s;
   logic             xfer_s;
   logic             wr_s;
   entry_t           wr_entry_s;
   logic             set_err_s;
   logic             inject_s;
   logic [2:0]       load_s;
   logic             rd_en_s;
   logic             m_valid_s;

   // A popped word is on FIFO_DOUT exactly one cycle after the pop.
   assign arrive_s  = inflight_r;
   assign m_valid_s = (occ_r != 2'd0);
   assign xfer_s    = m_valid_s & bus.M_READY;

`ifdef GLBL_RDR_TIMEOUT_EN
   logic [15:0] stall_r;

   // Stall counter: cycles spent in DATA waiting on an empty FIFO.
   always_ff @(posedge CK50 or posedge RST) begin
      if (RST) begin
         stall_r <= 16'h0000;
      end else if (arrive_s || (state_r != ST_DATA)) begin
         stall_r <= 16'h0000;
      end else if (bus.FIFO_EMPTY && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'h0001;
      end else begin
         stall_r <= stall_r;
      end
   end

   // The filler beat waits for a free buffer slot; counter saturates meanwhile.
   assign inject_s = (state_r == ST_DATA) && (stall_r == 16'hFFFF) && !arrive_s &&
                     !((occ_r == 2'd2) && !xfer_s);
`else
   assign inject_s = 1'b0;
`endif

   // Words buffered after this cycle's transfer plus words still in flight;
   // counting the outgoing beat keeps one pop per cycle under M_READY=1.
   always_comb begin
      load_s  = {1'b0, occ_r} + {2'b00, inflight_r} + {2'b00, inject_s} - {2'b00, xfer_s};
      rd_en_s = !RST && !bus.FIFO_EMPTY && (load_s < 3'd2);
   end

   // Framing FSM next state and the tag of the word entering the buffer.
   always_comb begin
      next_state_s = state_r;
      next_rem_s   = rem_r;
      next_chan_s  = chan_r;
      next_bc_s    = bc_r;
      wr_s         = 1'b0;
      wr_entry_s   = '0;
      set_err_s    = 1'b0;
      if (arrive_s) begin
         case (state_r)
            ST_HDR: begin
               if (bus.FIFO_DOUT[15]) begin
                  // Not a header: drop it and keep hunting for one.
                  set_err_s = 1'b1;
               end else begin
                  next_chan_s     = bus.FIFO_DOUT[14:12];
                  next_bc_s       = bus.FIFO_DOUT[11:0];
                  next_rem_s      = HOWMANY;
                  wr_s            = 1'b1;
                  wr_entry_s.data = bus.FIFO_DOUT;
                  wr_entry_s.sop  = 1'b1;
                  wr_entry_s.eop  = (HOWMANY == {SIZE{1'b0}});
                  wr_entry_s.chan = bus.FIFO_DOUT[14:12];
                  wr_entry_s.bc   = bus.FIFO_DOUT[11:0];
                  if (HOWMANY == {SIZE{1'b0}}) begin
                     next_state_s = ST_HDR;
                  end else begin
                     next_state_s = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               next_rem_s      = rem_r - {{(SIZE-1){1'b0}}, 1'b1};
               wr_s            = 1'b1;
               wr_entry_s.data = bus.FIFO_DOUT;
               wr_entry_s.sop  = 1'b0;
               wr_entry_s.eop  = (rem_r == {{(SIZE-1){1'b0}}, 1'b1});
               wr_entry_s.chan = chan_r;
               wr_entry_s.bc   = bc_r;
               if (rem_r == {{(SIZE-1){1'b0}}, 1'b1}) begin
                  next_state_s = ST_HDR;
               end else begin
                  next_state_s = ST_DATA;
               end
            end
            default: begin
               next_state_s = ST_HDR;
            end
         endcase
      end else if (inject_s) begin
         wr_s            = 1'b1;
         wr_entry_s.data = 16'hDEAD;
         wr_entry_s.sop  = 1'b0;
         wr_entry_s.eop  = 1'b1;
         wr_entry_s.chan = chan_r;
         wr_entry_s.bc   = bc_r;
         set_err_s       = 1'b1;
         next_rem_s      = {SIZE{1'b0}};
         next_state_s    = ST_HDR;
      end else begin
         next_state_s = state_r;
      end
   end

   // Framing state, event context, in-flight flag, sticky error.
   always_ff @(posedge CK50 or posedge RST) begin
      if (RST) begin
         state_r    <= ST_HDR;
         rem_r      <= {SIZE{1'b0}};
         chan_r     <= 3'd0;
         bc_r       <= 12'd0;
         inflight_r <= 1'b0;
         frm_err_r  <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         rem_r      <= next_rem_s;
         chan_r     <= next_chan_s;
         bc_r       <= next_bc_s;
         inflight_r <= rd_en_s;
         frm_err_r  <= frm_err_r | set_err_s;
      end
   end

   // Two-entry skid buffer; head_r always holds the beat being presented.
   always_ff @(posedge CK50 or posedge RST) begin
      if (RST) begin
         occ_r  <= 2'd0;
         head_r <= '0;
         tail_r <= '0;
      end else begin
         case ({wr_s, xfer_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  head_r <= wr_entry_s;
               end else begin
                  tail_r <= wr_entry_s;
               end
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               head_r <= tail_r;
               occ_r  <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  head_r <= wr_entry_s;
               end else begin
                  head_r <= tail_r;
                  tail_r <= wr_entry_s;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

   // BUSY follows delivered beats, not arrivals.
   always_ff @(posedge CK50 or posedge RST) begin
      if (RST) begin
         busy_r <= 1'b0;
      end else if (xfer_s) begin
         if (head_r.eop) begin
            busy_r <= 1'b0;
         end else if (head_r.sop) begin
            busy_r <= 1'b1;
         end else begin
            busy_r <= busy_r;
         end
      end else begin
         busy_r <= busy_r;
      end
   end

   assign bus.FIFO_RD_EN = rd_en_s;
   assign bus.M_VALID    = m_valid_s;
   assign bus.M_DATA     = head_r.data;
   assign bus.M_SOP      = head_r.sop & m_valid_s;
   assign bus.M_EOP      = head_r.eop & m_valid_s;
   assign bus.M_CHAN     = head_r.chan;
   assign bus.M_BC       = head_r.bc;
   assign BUSY           = busy_r;
   assign FRM_ERR        = frm_err_r;

endmodule

// File: tb/tb_glbl_fifo_reader.sv
module tb_glbl_fifo_reader;

   logic       ck50 = 1'b0;
   logic       rst  = 1'b0;
   logic [7:0] howmany;
   logic       busy;
   logic       frm_err;

   glbl_fifo_reader_if #(.WIDTH(16)) bus();

   glbl_fifo_reader #(.SIZE(8), .WIDTH(16)) dut (
      .CK50    (ck50),
      .RST     (rst),
      .bus     (bus),
      .HOWMANY (howmany),
      .BUSY    (busy),
      .FRM_ERR (frm_err)
   );

   always #10 ck50 = ~ck50;

   typedef struct packed {
      logic [15:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  chan;
      logic [11:0] bc;
   } beat_t;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] fifo_q[$];
   beat_t       exp_q[$];
   beat_t       got_q[$];
   int          got_cyc[$];
   int          pop_cyc[$];
   bit          inflight   = 1'b0;
   bit          rd_en_seen = 1'b0;
   logic [15:0] last_dout  = 16'h0000;
   int          cyc        = 0;
   int          ready_mode = 0;
   int          gen_left   = 0;

   // specification-level model of the event framing
   bit          m_hdr  = 1'b1;
   int          m_rem  = 0;
   logic [2:0]  m_chan = 3'd0;
   logic [11:0] m_bc   = 12'd0;
   bit          m_err  = 1'b0;
   bit          busy_m = 1'b0;
   bit          hold_prev = 1'b0;
   beat_t       prev_beat;
   beat_t       bas[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic beat_t mk(input logic [15:0] d, input logic s, input logic e,
                                input logic [2:0] c, input logic [11:0] b);
      beat_t r;
      r.data = d; r.sop = s; r.eop = e; r.chan = c; r.bc = b;
      return r;
   endfunction

   // Parse one word as it reaches the reader.
   task automatic model_word(input logic [15:0] w);
      if (m_hdr) begin
         if (w[15]) begin
            m_err = 1'b1;
         end else begin
            m_chan = w[14:12];
            m_bc   = w[11:0];
            m_rem  = int'(howmany);
            exp_q.push_back(mk(w, 1'b1, m_rem == 0, m_chan, m_bc));
            m_hdr = (m_rem == 0);
         end
      end else begin
         m_rem--;
         exp_q.push_back(mk(w, 1'b0, m_rem == 0, m_chan, m_bc));
         if (m_rem == 0) m_hdr = 1'b1;
      end
   endtask

   task automatic clear_model();
      fifo_q.delete();
      exp_q.delete();
      inflight   = 1'b0;
      rd_en_seen = 1'b0;
      m_hdr = 1'b1; m_rem = 0; m_chan = 3'd0; m_bc = 12'd0; m_err = 1'b0;
      busy_m = 1'b0; hold_prev = 1'b0; gen_left = 0;
      bus.FIFO_EMPTY = 1'b1;
   endtask

   task automatic push(input logic [15:0] w);
      fifo_q.push_back(w);
      bus.FIFO_EMPTY = 1'b0;
   endtask

   // One clock: FIFO model, word arrival, ready pattern.
   task automatic step();
      @(posedge ck50);
      #1;
      cyc++;
      if (inflight) model_word(last_dout);
      inflight = rd_en_seen;
      if (rd_en_seen) begin
         if (fifo_q.size() > 0) last_dout = fifo_q.pop_front();
         pop_cyc.push_back(cyc);
         bus.FIFO_DOUT = last_dout;
      end else begin
         bus.FIFO_DOUT = 16'($urandom);
      end
      bus.FIFO_EMPTY = (fifo_q.size() == 0);
      case (ready_mode)
         0:       bus.M_READY = 1'b1;
         1:       bus.M_READY = ((cyc % 3) == 0);
         default: bus.M_READY = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || inflight) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_drain_timeout"}, n < budget, 1'b1);
      repeat (4) step();
   endtask

   task automatic start_phase();
      got_q.delete();
      got_cyc.delete();
      pop_cyc.delete();
   endtask

   // Compare process: every cycle out of reset, checked against the model.
   always @(negedge ck50) begin
      beat_t cur;
      if (!rst) begin
         cur = mk(bus.M_DATA, bus.M_SOP, bus.M_EOP, bus.M_CHAN, bus.M_BC);
         chk("no_pop_when_empty", bus.FIFO_RD_EN && bus.FIFO_EMPTY, 1'b0);
         chk("buffered_plus_inflight_le2", (exp_q.size() + int'(inflight)) <= 2, 1'b1);
         chk("busy", busy, busy_m);
         chk("frm_err", frm_err, m_err);
         if (hold_prev) chk("hold_stable", {bus.M_VALID, cur}, {1'b1, prev_beat});
         if (bus.M_VALID && bus.M_READY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", cur, 64'h0);
               chk("unexpected_beat_count", 1'b1, 1'b0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat", cur, e);
               if (e.eop) busy_m = 1'b0;
               else if (e.sop) busy_m = 1'b1;
            end
            got_q.push_back(cur);
            got_cyc.push_back(cyc);
         end
         hold_prev  = bus.M_VALID && !bus.M_READY;
         prev_beat  = cur;
         rd_en_seen = bus.FIFO_RD_EN;
      end else begin
         hold_prev  = 1'b0;
         rd_en_seen = 1'b0;
      end
   end

   initial begin
      bus.FIFO_DOUT  = 16'h0000;
      bus.FIFO_EMPTY = 1'b1;
      bus.M_READY    = 1'b0;
      howmany        = 8'd0;
      bas[0] = mk(16'h2ABC, 1'b1, 1'b0, 3'd2, 12'hABC);
      bas[1] = mk(16'h0011, 1'b0, 1'b0, 3'd2, 12'hABC);
      bas[2] = mk(16'h0022, 1'b0, 1'b0, 3'd2, 12'hABC);
      bas[3] = mk(16'h0033, 1'b0, 1'b1, 3'd2, 12'hABC);

      // reset values
      #2 rst = 1'b1;
      #2;
      chk("rst_outputs", {bus.FIFO_RD_EN, bus.M_VALID, bus.M_SOP, bus.M_EOP, busy, frm_err}, 6'b0);
      chk("rst_data", {bus.M_DATA, bus.M_CHAN, bus.M_BC}, 31'h0);
      do_reset();

      // basic event, ready held high
      start_phase();
      ready_mode = 0; howmany = 8'd3;
      push(16'h2ABC); push(16'h0011); push(16'h0022); push(16'h0033);
      drain(50, "basic");
      chk("basic_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) if (i < got_q.size()) chk($sformatf("basic_beat%0d", i), got_q[i], bas[i]);
      chk("basic_pops", pop_cyc.size(), 4);
      if (pop_cyc.size() == 4) chk("basic_pop_rate", pop_cyc[3] - pop_cyc[0], 3);
      if (got_cyc.size() == 4) chk("basic_beat_rate", got_cyc[3] - got_cyc[0], 3);

      // backpressure
      start_phase();
      ready_mode = 1;
      push(16'h2ABC); push(16'h0011); push(16'h0022); push(16'h0033);
      drain(80, "bp");
      chk("bp_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) if (i < got_q.size()) chk($sformatf("bp_beat%0d", i), got_q[i], bas[i]);

      // zero-length events
      start_phase();
      ready_mode = 0; howmany = 8'd0;
      push(16'h7001); push(16'h1002);
      drain(40, "zero");
      chk("zero_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("zero_beat0", got_q[0], mk(16'h7001, 1'b1, 1'b1, 3'd7, 12'h001));
         chk("zero_beat1", got_q[1], mk(16'h1002, 1'b1, 1'b1, 3'd1, 12'h002));
      end

      // framing error
      start_phase();
      chk("frmerr_before", frm_err, 1'b0);
      ready_mode = 2; howmany = 8'd1;
      push(16'h8000); push(16'h3005); push(16'h0055);
      drain(60, "frm");
      chk("frmerr_set", frm_err, 1'b1);
      chk("frm_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("frm_beat0", got_q[0], mk(16'h3005, 1'b1, 1'b0, 3'd3, 12'h005));
         chk("frm_beat1", got_q[1], mk(16'h0055, 1'b0, 1'b1, 3'd3, 12'h005));
      end
      repeat (5) step();
      chk("frmerr_sticky", frm_err, 1'b1);

      // reset mid-frame
      do_reset();
      start_phase();
      ready_mode = 0; howmany = 8'd5;
      push(16'h4123);
      for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
      begin
         int n = 0;
         while (got_q.size() < 3 && n < 40) begin step(); n++; end
         chk("midrst_reach", got_q.size(), 3);
      end
      chk("midrst_busy_before", busy, 1'b1);
      #5 rst = 1'b1;
      clear_model();
      #1;
      chk("midrst_outputs", {bus.FIFO_RD_EN, bus.M_VALID, bus.M_SOP, bus.M_EOP, busy, frm_err}, 6'b0);
      chk("midrst_data", {bus.M_DATA, bus.M_CHAN, bus.M_BC}, 31'h0);
      repeat (2) step();
      rst = 1'b0;
      step();
      start_phase();
      howmany = 8'd0;
      push(16'h0007);
      drain(30, "postrst");
      chk("postrst_count", got_q.size(), 1);
      if (got_q.size() == 1) chk("postrst_hdr", got_q[0], mk(16'h0007, 1'b1, 1'b1, 3'd0, 12'h007));

      // 256-beat event
      start_phase();
      ready_mode = 2; howmany = 8'd255;
      push(16'h6FFF);
      for (int i = 0; i < 255; i++) push(16'($urandom_range(0, 16'hFFFF)));
      drain(2000, "max");
      chk("max_count", got_q.size(), 256);
      if (got_q.size() == 256) chk("max_last_eop", {got_q[255].eop, got_q[255].chan, got_q[255].bc}, {1'b1, 3'd6, 12'hFFF});

      // randomized traffic, HOWMANY changing at random points
      start_phase();
      ready_mode = 2; howmany = 8'd2;
      repeat (600) begin
         if ($urandom_range(0, 9) < 7) begin
            if (gen_left == 0) begin
               if ($urandom_range(0, 7) == 0) push(16'(16'h8000 | $urandom_range(0, 16'h7FFF)));
               else begin
                  push(16'($urandom_range(0, 16'h7FFF)));
                  gen_left = int'(howmany);
               end
            end else begin
               push(16'($urandom));
               gen_left--;
            end
         end
         if ($urandom_range(0, 24) == 0) howmany = 8'($urandom_range(0, 6));
         step();
      end
      drain(300, "random");
      chk("random_traffic_seen", got_q.size() > 50, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/glbl_fifo_reader.md
Name: glbl_fifo_reader

Overview:
- Drains the global event FIFO on its read side by driving the FIFO read enable.
- Parses the FIFO word stream into framed events. Each event is one header word {1'b0, CHSEL[2:0], BC[11:0]} followed by HOWMANY ADC sample words.
- Presents each event as a valid/ready beat stream with SOP/EOP, the channel number and the BC tag, for the PS-side DMA/bridge.
- Sits between fifo.dout/empty and the Zynq interface, and replaces direct ZYNQ_RD_REQUEST pulsing.

Parameters:
- SIZE, 8, width of the HOWMANY sample count.
- WIDTH, 16, FIFO word width; header layout is fixed for 16.

Ports:
- CK50  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- FIFO_DOUT  input  WIDTH  FIFO read data; valid one cycle after FIFO_RD_EN.
- FIFO_EMPTY  input  1  FIFO empty flag.
- FIFO_RD_EN  output  1  FIFO pop strobe.
- HOWMANY  input  SIZE  samples per event; sampled when a header is accepted.
- M_DATA  output  WIDTH  beat data.
- M_VALID  output  1  beat valid.
- M_READY  input  1  downstream ready.
- M_SOP  output  1  beat is the header word.
- M_EOP  output  1  beat is the last word of the event.
- M_CHAN  output  3  channel number of the current event.
- M_BC  output  12  BC tag of the current event.
- BUSY  output  1  high while an event is partially delivered.
- FRM_ERR  output  1  sticky framing error; cleared only by RST.

Behaviour:
- Reset values: FIFO_RD_EN=0, M_VALID=0, M_SOP=0, M_EOP=0, M_DATA=0, M_CHAN=0, M_BC=0, BUSY=0, FRM_ERR=0.
- Reset is asynchronous and may arrive mid-frame. All state clears, and any in-flight read word is discarded; the FIFO is reset alongside.
- FIFO read latency is 1 cycle. Returned words enter a 2-entry skid buffer.
- FIFO_RD_EN = !FIFO_EMPTY && (occupancy + inflight < 2). This sustains 1 word/cycle when M_READY is held high.
- FIFO_RD_EN never asserts while FIFO_EMPTY=1. No pop, no underflow.
- Output beat: the buffer head drives M_DATA and M_VALID. A beat transfers when M_VALID && M_READY.
- Output hold: while M_VALID=1 and M_READY=0, M_DATA, M_SOP, M_EOP, M_CHAN and M_BC stay stable.
- Framing FSM, advanced on word arrival into the buffer: HDR, DATA.
  - HDR: the arriving word is a header. Tag it SOP.
  - HDR actions: latch CHSEL=word[14:12], BC=word[11:0], and REM=HOWMANY.
  - HDR, REM=0: tag the header EOP as well and stay in HDR.
  - HDR, REM>0: go to DATA.
  - DATA: tag each arriving word with the latched CHSEL/BC and decrement REM.
  - DATA, REM reaches 0: tag that word EOP and go to HDR.
- Each buffer entry stores {data, sop, eop, chan, bc}. M_CHAN and M_BC therefore belong to the beat shown, not to later arrivals.
- Framing error: a word arriving in HDR with bit15=1 sets FRM_ERR. That word is dropped (not buffered) and the FSM stays in HDR to resynchronise.
- HOWMANY changes: a change mid-event has no effect on the current event.
- REM is SIZE bits wide. HOWMANY=255 gives 256 beats per event, with no wrap.
- BUSY=1 from the transfer of an SOP beat without EOP until the transfer of the EOP beat.
- Simultaneous word arrival and output transfer in the same cycle: occupancy is unchanged and both complete.

Optional Feature:
- Macro: GLBL_RDR_TIMEOUT_EN.
- When defined:
  - A 16-bit stall counter counts cycles with FSM=DATA && FIFO_EMPTY.
  - The counter resets on any word arrival.
  - At 16'hFFFF the reader injects a beat with M_DATA=16'hDEAD and EOP=1, sets FRM_ERR and returns to HDR.
  - A late-arriving remainder of that event is then treated as headers and flagged.
- When undefined: no counter; the reader waits indefinitely in DATA.

Test Plan:
- Basic event: HOWMANY=3; FIFO holds 0x2ABC, 0x0011, 0x0022, 0x0033; M_READY=1.
  -> 4 consecutive beats; SOP on 0x2ABC, EOP on 0x0033; M_CHAN=2, M_BC=0xABC on all; 4 pops, one per cycle.
- Backpressure: same event, M_READY toggling 1,0,0,1,... -> identical beat sequence; outputs stable during stalls; FIFO_RD_EN never leaves more than 2 words buffered or in flight.
- Zero-length events: HOWMANY=0; FIFO holds 0x7001, 0x1002 -> two beats, each with SOP=EOP=1; M_CHAN=7 then 1.
- Framing error: FIFO holds 0x8000, then 0x3005 + 1 sample, HOWMANY=1 -> FRM_ERR=1 and stays set; 0x8000 not output; following event delivered correctly.
- Reset mid-frame: RST asserted after 2 of 5 data beats -> all outputs 0 immediately; after release, the next FIFO word is parsed as a header.
- Timeout (GLBL_RDR_TIMEOUT_EN): header + 1 of 3 samples, then FIFO empty for 65535 cycles -> 0xDEAD beat with EOP=1 and FRM_ERR=1.
